// File: rtl/count_cam_scheduler.sv
// count_cam_scheduler: round-robin arbiter driving the count CAM search/write sequence; optional WAIT watchdog under COUNT_CAM_SCHED_TIMEOUT_EN
module count_cam_scheduler #(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = 3,
    parameter int THRESHOLD = 1000,
    parameter int TIMEOUT   = 64,
    localparam int BW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*CNT_W-1:0]   req_sp_cnt_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     resp_hit_o,
    output logic [IDX_W-1:0]         resp_idx_o,
    output logic                     rfm_o,
    output logic [BW-1:0]            rfm_bank_o,
    output logic                     cam_search_o,
    output logic [CNT_W-1:0]         cam_sp_cnt_o,
    output logic [BW-1:0]            cam_bank_id_o,
    output logic [IDX_W-1:0]         cam_inc_idx_o,
    input  logic                     cam_valid_i,
    input  logic                     cam_hit_i,
    input  logic [IDX_W-1:0]         cam_idx_i,
    output logic                     err_o
);
    typedef enum logic [2:0] {IDLE, SEARCH, WAIT, WRITE, DONE} state_e;
    localparam int SW = CNT_W + 1;
    localparam logic [CNT_W:0] THR = SW'(THRESHOLD);
    state_e           state_q, state_d;
    logic [BW-1:0]    rr_q, rr_d, win_q, win_d, gnt_idx;
    logic [CNT_W-1:0] sp_q, sp_d;
    logic [IDX_W-1:0] inc_q, inc_d, vic_q, vic_d, idx_q, idx_d;
    logic             hit_q, hit_d, gnt_found, done;
    logic [CNT_W:0]   sum;
    int               cand;
`ifdef COUNT_CAM_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
`endif

    // pick the first requester at or after rr_q, cyclically
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(rr_q) + i) % N_REQ;
            if (!gnt_found && req_valid_i[cand[BW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[BW-1:0];
            end
        end
    end

    // next-state and transaction bookkeeping
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        sp_d    = sp_q;
        inc_d   = inc_q;
        vic_d   = vic_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
`ifdef COUNT_CAM_SCHED_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (gnt_found) begin
                win_d   = gnt_idx;
                sp_d    = req_sp_cnt_i[int'(gnt_idx)*CNT_W +: CNT_W];
                inc_d   = vic_q;
                state_d = SEARCH;
            end
            SEARCH: begin
`ifdef COUNT_CAM_SCHED_TIMEOUT_EN
                wcnt_d  = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (cam_valid_i) begin
                    hit_d   = cam_hit_i;
                    idx_d   = cam_idx_i;
                    state_d = cam_hit_i ? DONE : WRITE;
                end
`ifdef COUNT_CAM_SCHED_TIMEOUT_EN
                else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = DONE;
                end else wcnt_d = wcnt_q + WW'(1);
`endif
            end
            WRITE: begin
                vic_d   = vic_q + IDX_W'(1);
                idx_d   = inc_q;
                state_d = DONE;
            end
            DONE: begin
                rr_d    = (win_q == BW'(N_REQ - 1)) ? '0 : win_q + BW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and transaction registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            sp_q    <= '0;
            inc_q   <= '0;
            vic_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            sp_q    <= sp_d;
            inc_q   <= inc_d;
            vic_q   <= vic_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

`ifdef COUNT_CAM_SCHED_TIMEOUT_EN
    // watchdog counter and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // the increment is done one bit wider so an all-ones count still reaches the threshold
    assign sum           = {1'b0, sp_q} + SW'(1);
    assign done          = state_q == DONE;
    assign ack_o         = done ? (N_REQ'(1) << win_q) : '0;
    assign resp_hit_o    = done & hit_q;
    assign resp_idx_o    = done ? idx_q : '0;
    assign rfm_o         = done & hit_q & (sum >= THR);
    assign rfm_bank_o    = rfm_o ? win_q : '0;
    assign cam_search_o  = state_q == SEARCH;
    assign cam_sp_cnt_o  = sp_q;
    assign cam_bank_id_o = win_q;
    assign cam_inc_idx_o = inc_q;
endmodule

// File: tb/tb_count_cam_scheduler.sv
// tb_count_cam_scheduler: randomized and directed checks of count_cam_scheduler against a transaction-timeline model
module tb_count_cam_scheduler;
    localparam int N = 4, CW = 16, IW = 3, THR = 1000, TO = 64;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0, rst_ni = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N*CW-1:0] req_sp = '0;
    logic cam_valid = 1'b0, cam_hit = 1'b0;
    logic [IW-1:0] cam_idx = '0;
    logic [N-1:0] ack;
    logic resp_hit, rfm, cam_search, err;
    logic [IW-1:0] resp_idx, cam_inc;
    logic [1:0] rfm_bank, cam_bank;
    logic [CW-1:0] cam_sp;

    count_cam_scheduler #(.N_REQ(N), .CNT_W(CW), .IDX_W(IW), .THRESHOLD(THR), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_sp_cnt_i(req_sp),
        .ack_o(ack), .resp_hit_o(resp_hit), .resp_idx_o(resp_idx), .rfm_o(rfm), .rfm_bank_o(rfm_bank),
        .cam_search_o(cam_search), .cam_sp_cnt_o(cam_sp), .cam_bank_id_o(cam_bank), .cam_inc_idx_o(cam_inc),
        .cam_valid_i(cam_valid), .cam_hit_i(cam_hit), .cam_idx_i(cam_idx), .err_o(err));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int mode = 0, f_sp = 0, f_hit = 0, f_idx = 0, f_d = 0;
    bit pend[N];
    int sp_arr[N];
    bit m_active = 0, m_hit = 0, m_to = 0, m_err = 0;
    int m_win = 0, m_sp = 0, m_inc = 0, m_idx = 0, m_search = 0, m_valid = 0, m_done = 0, m_rr = 0, m_victim = 0;
    int lb[$], lh[$], li[$], lr[$], lrb[$], lbid[$], linc[$];

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
        end
    endtask

    task automatic clear_log();
        lb.delete(); lh.delete(); li.delete(); lr.delete(); lrb.delete(); lbid.delete(); linc.delete();
    endtask

    function automatic bit any_pend();
        bit r;
        r = 0;
        for (int i = 0; i < N; i++) r |= pend[i];
        return r;
    endfunction

    function automatic int pick_sp();
        case ($urandom % 6)
            0: return 5;
            1: return 998;
            2: return 999;
            3: return 1000;
            4: return 'hFFFF;
            default: return int'($urandom % 65536);
        endcase
    endfunction

    task automatic compare();
        bit e_done, e_rfm;
        int e_idx, b;
        e_done = m_active && cyc == m_done;
        e_idx  = !e_done ? 0 : m_to ? 0 : m_hit ? m_idx : m_inc;
        e_rfm  = e_done && m_hit && (m_sp + 1 >= THR);
        chk("ack", 32'(ack), e_done ? 32'(1 << m_win) : 32'd0);
        chk("resp_hit", 32'(resp_hit), 32'(e_done && m_hit));
        chk("resp_idx", 32'(resp_idx), 32'(e_idx));
        chk("rfm", 32'(rfm), 32'(e_rfm));
        chk("rfm_bank", 32'(rfm_bank), e_rfm ? 32'(m_win) : 32'd0);
        chk("search", 32'(cam_search), 32'(m_active && cyc == m_search));
        chk("err", 32'(err), 32'(m_err || (e_done && m_to)));
        if (m_active) begin
            chk("cam_sp", 32'(cam_sp), 32'(m_sp));
            chk("cam_bank", 32'(cam_bank), 32'(m_win));
            chk("cam_inc", 32'(cam_inc), 32'(m_inc));
        end
        if (ack != 0) begin
            b = 0;
            for (int i = 0; i < N; i++) if (ack[i]) b = i;
            lb.push_back(b); lh.push_back(int'(resp_hit)); li.push_back(int'(resp_idx));
            lr.push_back(int'(rfm)); lrb.push_back(int'(rfm_bank));
            lbid.push_back(int'(cam_bank)); linc.push_back(int'(cam_inc));
        end
    endtask

    task automatic drive();
        bit in_wait;
        for (int i = 0; i < N; i++) begin
            if (mode == 2) pend[i] = 1;
            else if (mode == 0 && !pend[i] && $urandom % 3 == 0) pend[i] = 1;
            req_valid[i] = pend[i] && !(mode == 0 && m_active && i == m_win && $urandom % 2 == 1);
            sp_arr[i] = (mode == 0) ? pick_sp() : f_sp;
            req_sp[i*CW +: CW] = CW'(sp_arr[i]);
        end
        in_wait = m_active && cyc > m_search && cyc <= m_valid && cyc < m_done;
        if (in_wait) begin
            cam_valid = (cyc == m_valid);
            cam_hit   = cam_valid ? m_hit : 1'($urandom % 2);
            cam_idx   = cam_valid ? IW'(m_idx) : IW'($urandom);
        end else begin
            cam_valid = (mode == 0) && ($urandom % 4 == 0);
            cam_hit   = 1'($urandom % 2);
            cam_idx   = IW'($urandom);
        end
    endtask

    task automatic model();
        int d, b;
        bit found;
        if (m_active) begin
            if (cyc == m_done) begin
                pend[m_win] = 0;
                m_rr = (m_win + 1) % N;
                if (!m_hit && !m_to) m_victim = (m_victim + 1) % 8;
                if (m_to) m_err = 1;
                m_active = 0;
            end
        end else if (req_valid != 0) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                b = (m_rr + i) % N;
                if (!found && req_valid[b]) begin
                    found = 1;
                    m_win = b;
                end
            end
            m_sp = sp_arr[m_win]; m_inc = m_victim; m_active = 1; m_search = cyc + 1; m_to = 0;
            if (mode == 0) begin
                m_hit = bit'($urandom % 2); m_idx = int'($urandom % 8); d = int'($urandom % 4);
            end else begin
                m_hit = bit'(f_hit); m_idx = f_idx; d = f_d;
            end
            if (d < 0) begin
                m_valid = BIG;
`ifdef COUNT_CAM_SCHED_TIMEOUT_EN
                m_to = 1; m_hit = 0; m_done = m_search + TO + 1;
`else
                m_done = BIG;
`endif
            end else begin
                m_valid = cyc + 2 + d;
                m_done  = m_valid + (m_hit ? 1 : 2);
            end
        end
    endtask

    task automatic step();
        compare();
        drive();
        model();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_idle(int bound);
        int n;
        n = 0;
        while ((m_active || any_pend()) && n < bound) begin
            step();
            n++;
        end
        chk("drain_bound", 32'(n < bound), 32'd1);
    endtask

    task automatic txn(int req, int sp, int hit, int idx, int d);
        mode = 1; f_sp = sp; f_hit = hit; f_idx = idx; f_d = d;
        for (int i = 0; i < N; i++) pend[i] = req[i];
        run_idle(200);
    endtask

    task automatic do_reset();
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_hit", 32'(resp_hit), 32'd0);
        chk("rst_idx", 32'(resp_idx), 32'd0);
        chk("rst_rfm", 32'(rfm), 32'd0);
        chk("rst_rfm_bank", 32'(rfm_bank), 32'd0);
        chk("rst_search", 32'(cam_search), 32'd0);
        chk("rst_cam_sp", 32'(cam_sp), 32'd0);
        chk("rst_cam_bank", 32'(cam_bank), 32'd0);
        chk("rst_cam_inc", 32'(cam_inc), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        m_active = 0; m_rr = 0; m_victim = 0; m_err = 0; m_to = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        req_valid = '0; cam_valid = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        @(negedge clk);
        do_reset();
        clear_log();
        txn(4, 5, 1, 3, 1);
        chk("hit_count", 32'(lb.size()), 32'd1);
        if (lb.size() == 1) begin
            chk("hit_bank", 32'(lb[0]), 32'd2);
            chk("hit_flag", 32'(lh[0]), 32'd1);
            chk("hit_idx", 32'(li[0]), 32'd3);
            chk("hit_rfm", 32'(lr[0]), 32'd0);
            chk("hit_bank_id", 32'(lbid[0]), 32'd2);
        end
        clear_log();
        txn(1, 7, 0, 5, 0);
        txn(1, 7, 0, 6, 2);
        chk("miss_count", 32'(lb.size()), 32'd2);
        if (lb.size() == 2) begin
            chk("miss_inc0", 32'(linc[0]), 32'd0);
            chk("miss_inc1", 32'(linc[1]), 32'd1);
            chk("miss_idx0", 32'(li[0]), 32'd0);
            chk("miss_idx1", 32'(li[1]), 32'd1);
            chk("miss_hit0", 32'(lh[0]), 32'd0);
        end
        clear_log();
        txn(2, 999, 1, 4, 0);
        txn(8, 998, 1, 4, 0);
        txn(1, 'hFFFF, 1, 2, 3);
        chk("thr_count", 32'(lb.size()), 32'd3);
        if (lb.size() == 3) begin
            chk("thr_999", 32'(lr[0]), 32'd1);
            chk("thr_999_bank", 32'(lrb[0]), 32'd1);
            chk("thr_998", 32'(lr[1]), 32'd0);
            chk("thr_ffff", 32'(lr[2]), 32'd1);
        end
        do_reset();
        clear_log();
        mode = 2;
        n = 0;
        while (lb.size() < 5 && n < 100) begin
            step();
            n++;
        end
        mode = 1;
        run_idle(200);
        chk("rr_count", 32'(lb.size() >= 5), 32'd1);
        if (lb.size() >= 5) begin
            chk("rr_0", 32'(lb[0]), 32'd0);
            chk("rr_1", 32'(lb[1]), 32'd1);
            chk("rr_2", 32'(lb[2]), 32'd2);
            chk("rr_3", 32'(lb[3]), 32'd3);
            chk("rr_4", 32'(lb[4]), 32'd0);
        end
        clear_log();
        f_d = -1; f_hit = 1; f_idx = 0;
        pend[0] = 1;
        repeat (4) step();
        do_reset();
        chk("rst_wait_no_ack", 32'(lb.size()), 32'd0);
        txn(2, 10, 1, 6, 0);
        chk("post_rst_count", 32'(lb.size()), 32'd1);
        if (lb.size() == 1) begin
            chk("post_rst_bank", 32'(lb[0]), 32'd1);
            chk("post_rst_idx", 32'(li[0]), 32'd6);
        end
        clear_log();
`ifdef COUNT_CAM_SCHED_TIMEOUT_EN
        txn(1, 999, 1, 3, -1);
        chk("wd_count", 32'(lb.size()), 32'd1);
        if (lb.size() == 1) begin
            chk("wd_hit", 32'(lh[0]), 32'd0);
            chk("wd_idx", 32'(li[0]), 32'd0);
            chk("wd_rfm", 32'(lr[0]), 32'd0);
        end
        chk("wd_err", 32'(err), 32'd1);
        txn(4, 5, 0, 0, 0);
        chk("wd_err_sticky", 32'(err), 32'd1);
        if (lb.size() == 2) chk("wd_victim_kept", 32'(linc[1]), 32'd0);
`else
        mode = 1; f_d = -1;
        pend[0] = 1;
        repeat (100) step();
        chk("wd_off_no_ack", 32'(lb.size()), 32'd0);
        chk("wd_off_err", 32'(err), 32'd0);
`endif
        do_reset();
        mode = 0;
        repeat (3000) step();
        mode = 1; f_d = 1; f_hit = 1; f_idx = 2;
        run_idle(500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_cam_scheduler.md
# count_cam_scheduler

Round-robin front-end for the activation-count CAM. Arbitrates per-bank activation requests, drives the CAM search/write sequence for one request at a time, returns hit/index responses and raises a preventive-refresh request when a row's shared counter reaches the threshold. It sits between the bank request logic and a single count CAM instance.

## Interface
- `N_REQ`, 4: number of requesters (banks).
- `CNT_W`, 16: spillover counter width; matches the CAM data width.
- `IDX_W`, 3: CAM entry index width (log2 of N_ENTRY).
- `THRESHOLD`, 1000: refresh threshold on the post-increment count.
- `TIMEOUT`, 64: watchdog limit in WAIT cycles; must exceed N_ENTRY+2.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in N_REQ: per-bank request. Held until the matching `ack_o` bit.
- `req_sp_cnt_i` in N_REQ*CNT_W: flattened per-bank counter values. Slice i is for bank i.
- `ack_o` out N_REQ: one-hot, one-cycle completion pulse.
- `resp_hit_o` out 1: CAM hit for the acked request. Valid with `ack_o`.
- `resp_idx_o` out IDX_W: entry matched (hit) or entry written (miss). Valid with `ack_o`.
- `rfm_o` out 1: one-cycle preventive-refresh pulse, coincident with `ack_o`.
- `rfm_bank_o` out clog2(N_REQ): bank for `rfm_o`.
- `cam_search_o` out 1: CAM search strobe.
- `cam_sp_cnt_o` out CNT_W: counter value searched.
- `cam_bank_id_o` out clog2(N_REQ): bank id presented to the CAM.
- `cam_inc_idx_o` out IDX_W: victim index for the CAM write after a miss.
- `cam_valid_i` in 1: CAM result valid.
- `cam_hit_i` in 1: CAM hit.
- `cam_idx_i` in IDX_W: CAM matched address.
- `err_o` out 1: sticky watchdog error.

## Operation
States: IDLE, SEARCH, WAIT, WRITE, DONE.
- **IDLE**
  - If any `req_valid_i` bit is set, grant the first set bit at or after `rr_ptr`, cyclically.
  - Latch the winner index and its `req_sp_cnt_i` slice, then go to SEARCH.
  - `req_sp_cnt_i` is sampled only at grant; later changes are ignored.
- **SEARCH**: assert `cam_search_o` for exactly one cycle, clear the wait counter, go to WAIT.
- **WAIT**
  - On `cam_valid_i`: latch `cam_hit_i` and `cam_idx_i`. Hit goes to DONE; miss goes to WRITE.
  - Otherwise increment the wait counter.
- **WRITE**: one cycle while the CAM performs its write at `cam_inc_idx_o`. Then `victim_ptr` increments (wraps at 2^IDX_W), `resp_idx_o` becomes the written index, and the FSM goes to DONE.
- **DONE**
  - Pulse the winner's `ack_o` bit with the response.
  - `rfm_o` = hit AND (`sp_cnt` + 1 ≥ THRESHOLD). The sum is computed at CNT_W+1 bits, so all-ones + 1 does not wrap.
  - `rr_ptr` becomes winner + 1 mod N_REQ. Go to IDLE.
- `cam_sp_cnt_o`, `cam_bank_id_o` and `cam_inc_idx_o` stay stable from SEARCH through WRITE/DONE.
- A requester dropping `req_valid_i` before ack does not abort the transaction; it is still acked.

## Timing
- Reset (async assert): state IDLE. All outputs 0, including `err_o`. `rr_ptr` and `victim_ptr` are 0. An in-flight transaction is dropped with no ack.
- Reset release is synchronous to `clk_i`.
- Grant happens in the cycle `req_valid_i` is seen in IDLE. `cam_search_o` is high the following cycle.
- Hit latency, request to `ack_o`: 3 cycles plus CAM search time. Miss latency adds 1 cycle for WRITE.
- Minimum spacing between grants is 4 cycles. Back-to-back requests from all banks are served in rotation with no starvation.
- Simultaneous requests: only one is granted per IDLE cycle; the others wait.
- `cam_valid_i` outside WAIT is ignored.

## Configuration
- `COUNT_CAM_SCHED_TIMEOUT_EN` defined:
  - If the wait counter reaches TIMEOUT in WAIT, set `err_o` (sticky until reset).
  - Ack the request with `resp_hit_o`=0 and `resp_idx_o`=0, no `rfm_o`, and `victim_ptr` unchanged.
  - Return to IDLE via DONE.
- Not defined: WAIT holds indefinitely, `err_o` is tied 0, and no wait counter is built.

## Test plan
- **Reset mid-WAIT**: pulse `rst_ni` low during WAIT -> all outputs 0 immediately, no ack, next request granted normally.
- **Single hit**: bank 2 requests sp_cnt=5, CAM returns hit idx 3 -> `ack_o`=4'b0100, `resp_hit_o`=1, `resp_idx_o`=3, `cam_bank_id_o`=2, no `rfm_o`.
- **Miss sequence**: two misses from bank 0 -> WRITE state seen; `cam_inc_idx_o` is 0 then 1; `resp_idx_o` is 0 then 1.
- **Threshold**: THRESHOLD=1000, sp_cnt=999 with hit -> `rfm_o`=1, `rfm_bank_o` = requester. Same with sp_cnt=998 -> no `rfm_o`. With CNT_W=16 and sp_cnt=16'hFFFF hit -> `rfm_o`=1 (no wrap).
- **Round-robin**: all 4 banks request continuously -> ack order 0,1,2,3,0; no `ack_o` more than one-hot.
- **Watchdog** (macro on, TIMEOUT=64): CAM never asserts valid -> ack after 64 WAIT cycles, `err_o`=1 sticky, `resp_hit_o`=0. With the macro off: no ack and `err_o`=0.
